// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging NUM_CH cache requesters onto one memory port, one transaction
// in flight. Define MEM_ARB_PRIO_EN to give channel 0 absolute priority over the others.
module mem_port_arbiter #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [2*NUM_CH-1:0]          ch_rw_flag,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    input  logic [NUM_CH*MASK_WIDTH-1:0] ch_mask,
    output logic [NUM_CH-1:0]            ch_grant,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    input  logic                         mem_free,
    input  logic                         mem_read_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic [1:0]                   mem_rw_flag,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [MASK_WIDTH-1:0]        mem_mask
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  ptr_next;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] rr_elig;
    logic              found;

    // A channel in its own done cycle is masked so a still-held request is not re-sampled.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig[i] = ch_req[i] && !ch_done[i] &&
                      (ch_rw_flag[2*i +: 2] == OpRead || ch_rw_flag[2*i +: 2] == OpWrite);
        end
    end

    always_comb begin
        rr_elig = elig;
`ifdef MEM_ARB_PRIO_EN
        rr_elig[0] = 1'b0;
`endif
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_CH);
            if (!found && rr_elig[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef MEM_ARB_PRIO_EN
        if (elig[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        ptr_next = (32'(winner) == NUM_CH - 1) ? '0 : winner + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            ch_grant    <= '0;
            ch_done     <= '0;
            ch_rdata    <= '0;
            mem_rw_flag <= OpNone;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_mask    <= '0;
        end else begin
            ch_grant <= '0;
            ch_done  <= '0;
            case (state_q)
                StIdle: begin
                    if (found) begin
                        idx_q            <= winner;
                        mem_rw_flag      <= ch_rw_flag[2*winner +: 2];
                        mem_addr         <= ch_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata        <= ch_wdata[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        mem_mask         <= ch_mask[32'(winner)*MASK_WIDTH +: MASK_WIDTH];
                        ch_grant[winner] <= 1'b1;
`ifdef MEM_ARB_PRIO_EN
                        if (winner != '0) begin
                            rr_ptr_q <= ptr_next;
                        end
`else
                        rr_ptr_q <= ptr_next;
`endif
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    // The latched op lives in mem_rw_flag for as long as the command is held.
                    if (mem_free) begin
                        mem_rw_flag <= OpNone;
                        if (mem_rw_flag == OpWrite) begin
                            ch_done[idx_q] <= 1'b1;
                            state_q        <= StIdle;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_read_valid) begin
                        ch_rdata       <= mem_rdata;
                        ch_done[idx_q] <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NUM_CH=2): stimulus pushes expected grants/completions
// into queues, a negedge monitor pops and compares them as the DUT emits them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_req;
    logic [3:0]  ch_rw_flag;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [7:0]  ch_mask;
    logic [1:0]  ch_grant;
    logic [1:0]  ch_done;
    logic [31:0] ch_rdata;
    logic        mem_free;
    logic        mem_read_valid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rw_flag;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;

    typedef struct {
        logic [1:0]  ch;
        logic        is_rd;
        logic [31:0] rdata;
    } done_t;

    logic [1:0] grant_q[$];
    done_t      done_q[$];
    logic [1:0] mon_g;
    done_t      mon_d;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .NUM_CH    (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MASK_WIDTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_req        (ch_req),
        .ch_rw_flag    (ch_rw_flag),
        .ch_addr       (ch_addr),
        .ch_wdata      (ch_wdata),
        .ch_mask       (ch_mask),
        .ch_grant      (ch_grant),
        .ch_done       (ch_done),
        .ch_rdata      (ch_rdata),
        .mem_free      (mem_free),
        .mem_read_valid(mem_read_valid),
        .mem_rdata     (mem_rdata),
        .mem_rw_flag   (mem_rw_flag),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_mask      (mem_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [1:0] rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        ch_rw_flag[2*c +: 2] = rw;
        ch_addr[32*c +: 32]  = addr;
        ch_wdata[32*c +: 32] = wdata;
        ch_mask[4*c +: 4]    = mask;
    endtask

    task automatic push_done(input logic [1:0] ch, input logic is_rd, input logic [31:0] rd);
        done_t d;
        d.ch    = ch;
        d.is_rd = is_rd;
        d.rdata = rd;
        done_q.push_back(d);
    endtask

    // Monitor: every grant/done pulse must match the next expected entry.
    always @(negedge clk) begin
        if (ch_grant != 2'b00) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", 64'(ch_grant), 64'd0);
            end else begin
                mon_g = grant_q.pop_front();
                check("grant", 64'(ch_grant), 64'(mon_g));
            end
        end
        if (ch_done != 2'b00) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 64'(ch_done), 64'd0);
            end else begin
                mon_d = done_q.pop_front();
                check("done", 64'(ch_done), 64'(mon_d.ch));
                if (mon_d.is_rd) check("done_rdata", 64'(ch_rdata), 64'(mon_d.rdata));
            end
        end
    end

    initial begin
        rst = 1'b1;
        ch_req = '0; ch_rw_flag = '0; ch_addr = '0; ch_wdata = '0; ch_mask = '0;
        mem_free = 1'b0; mem_read_valid = 1'b0; mem_rdata = '0;
        repeat (3) tick;
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_ctrl", 64'({ch_grant, ch_done, mem_rw_flag}), 64'd0);
            check("idle_data", {ch_rdata, mem_addr}, 64'd0);
        end

        // Ch1 write
        mem_free = 1'b1;
        set_ch(1, 2'b10, 32'h40, 32'hDEADBEEF, 4'b0011);
        ch_req = 2'b10;
        grant_q.push_back(2'b10);
        push_done(2'b10, 1'b0, 32'h0);
        tick;
        check("wr_flag", 64'(mem_rw_flag), 64'h2);
        check("wr_addr", 64'(mem_addr), 64'h40);
        check("wr_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("wr_mask", 64'(mem_mask), 64'h3);
        check("wr_grant_lat", 64'(ch_grant), 64'h2);
        tick;
        check("wr_done_lat", 64'(ch_done), 64'h2);
        check("wr_flag_clear", 64'(mem_rw_flag), 64'h0);
        ch_req = 2'b00;
        set_ch(1, 2'b00, 32'h0, 32'h0, 4'h0);
        tick;
        check("rdata_untouched_by_wr", 64'(ch_rdata), 64'h0);

        // Ch0 read, data returned three cycles after the request
        set_ch(0, 2'b01, 32'h100, 32'h0, 4'h0);
        ch_req = 2'b01;
        grant_q.push_back(2'b01);
        push_done(2'b01, 1'b1, 32'h12345678);
        tick;
        check("rd_flag", 64'(mem_rw_flag), 64'h1);
        check("rd_addr", 64'(mem_addr), 64'h100);
        tick;
        check("rd_wait_flag", 64'(mem_rw_flag), 64'h0);
        tick;
        mem_read_valid = 1'b1;
        mem_rdata = 32'h12345678;
        tick;
        mem_read_valid = 1'b0;
        mem_rdata = 32'h0;
        check("rd_done_lat", 64'(ch_done), 64'h1);
        check("rd_rdata", 64'(ch_rdata), 64'h12345678);
        ch_req = 2'b00;
        set_ch(0, 2'b00, 32'h0, 32'h0, 4'h0);
        tick;

        // Both channels writing continuously: rr_ptr is 1 here
        set_ch(0, 2'b10, 32'h10, 32'h11110000, 4'hF);
        set_ch(1, 2'b10, 32'h20, 32'h22220000, 4'hF);
        ch_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_PRIO_EN
            mon_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            mon_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
            grant_q.push_back(mon_g);
            push_done(mon_g, 1'b0, 32'h0);
        end
        repeat (8) tick;
        ch_req = 2'b00;
        set_ch(0, 2'b00, 32'h0, 32'h0, 4'h0);
        set_ch(1, 2'b00, 32'h0, 32'h0, 4'h0);
        tick;
        check("alt_idle", 64'({ch_grant, mem_rw_flag}), 64'h0);

        // Stall in ISSUE; requester drops req and changes payload, stray read_valid
        mem_free = 1'b0;
        set_ch(0, 2'b10, 32'h200, 32'hA5A5A5A5, 4'hF);
        ch_req = 2'b01;
        grant_q.push_back(2'b01);
        push_done(2'b01, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("stall_flag_addr", {30'h0, mem_rw_flag, mem_addr}, {30'h0, 2'b10, 32'h200});
            check("stall_wdata_mask", {28'h0, mem_wdata, mem_mask}, {28'h0, 32'hA5A5A5A5, 4'hF});
            check("stall_no_done", 64'(ch_done), 64'h0);
            if (i == 1) begin
                set_ch(0, 2'b10, 32'h999, 32'h0, 4'h0);
                ch_req = 2'b00;
            end
            if (i == 2) begin
                mem_read_valid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
            if (i == 3) mem_read_valid = 1'b0;
        end
        mem_free = 1'b1;
        tick;
        check("stall_done", 64'(ch_done), 64'h1);
        check("stall_flag_clear", 64'(mem_rw_flag), 64'h0);
        check("stall_rdata_kept", 64'(ch_rdata), 64'h12345678);
        set_ch(0, 2'b00, 32'h0, 32'h0, 4'h0);
        tick;

        // Ch1 with op 11 is never granted; ch0 read is served
        set_ch(1, 2'b11, 32'h700, 32'h0, 4'h0);
        set_ch(0, 2'b01, 32'h300, 32'h0, 4'h0);
        ch_req = 2'b11;
        grant_q.push_back(2'b01);
        push_done(2'b01, 1'b1, 32'hCAFEF00D);
        tick;
        check("bad_op_rd_cmd", {30'h0, mem_rw_flag, mem_addr}, {30'h0, 2'b01, 32'h300});
        tick;
        mem_read_valid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick;
        mem_read_valid = 1'b0;
        check("bad_op_rd_done", 64'(ch_done), 64'h1);
        check("bad_op_rdata", 64'(ch_rdata), 64'hCAFEF00D);
        ch_req = 2'b10;
        set_ch(0, 2'b00, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bad_op_idle", 64'({ch_grant, mem_rw_flag}), 64'h0);
        end
        ch_req = 2'b00;
        set_ch(1, 2'b00, 32'h0, 32'h0, 4'h0);
        tick;

        // Reset while waiting for read data abandons the transaction
        set_ch(1, 2'b01, 32'h500, 32'h0, 4'h0);
        ch_req = 2'b10;
        grant_q.push_back(2'b10);
        tick;
        tick;
        check("rst_wait_flag", 64'(mem_rw_flag), 64'h0);
        rst = 1'b1;
        mem_read_valid = 1'b1;
        mem_rdata = 32'h55;
        tick;
        rst = 1'b0;
        mem_read_valid = 1'b0;
        ch_req = 2'b00;
        set_ch(1, 2'b00, 32'h0, 32'h0, 4'h0);
        check("rst_ctrl", 64'({ch_done, ch_grant, mem_rw_flag}), 64'h0);
        check("rst_rdata", 64'(ch_rdata), 64'h0);
        set_ch(0, 2'b10, 32'h600, 32'h77, 4'h1);
        ch_req = 2'b01;
        grant_q.push_back(2'b01);
        push_done(2'b01, 1'b0, 32'h0);
        tick;
        check("post_rst_grant", 64'(ch_grant), 64'h1);
        check("post_rst_flag", 64'(mem_rw_flag), 64'h2);
        tick;
        check("post_rst_done", 64'(ch_done), 64'h1);
        ch_req = 2'b00;
        set_ch(0, 2'b00, 32'h0, 32'h0, 4'h0);
        repeat (3) tick;

        check("grant_q_drained", 64'(grant_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
